// File: rtl/filter_host.sv
// filter_host: loads a frame of samples into the sample RAM, runs the filter controller
// over ctrl/bsy, then streams the results out. Define FHOST_TIMEOUT_EN for the START/WAIT watchdog.
module filter_host #(
  parameter int DEPTH   = 32,
  parameter int DW      = 16,
  parameter int AW      = 6,
  parameter int TIMEOUT = 1023
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [1:0]    ctrl,
  input  logic          bsy,
  output logic [AW-1:0] res_addr,
  input  logic [DW-1:0] res_rdata,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    CLR, LOAD, START, WAIT, FETCH, LATCH, SEND
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        state;
  logic [AW-1:0] k;

`ifdef FHOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wd_cnt;
  logic          wd_hit;
  assign wd_hit = (wd_cnt == TW'(TIMEOUT - 1));
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= CLR;
      k         <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ctrl      <= 2'b00;
      res_addr  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
`ifdef FHOST_TIMEOUT_EN
      wd_cnt    <= '0;
      err       <= 1'b0;
`endif
    end else begin
      // single-cycle strobes
      mem_we   <= 1'b0;
      done     <= 1'b0;
      res_addr <= '0;

      case (state)
        CLR: begin
          ctrl  <= 2'b10;
          k     <= '0;
          state <= LOAD;
        end

        LOAD: begin
          ctrl     <= 2'b00;
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            mem_we    <= 1'b1;
            mem_addr  <= k;
            mem_wdata <= in_data;
            if (k == LAST) begin
              in_ready <= 1'b0;
              k        <= '0;
              ctrl     <= 2'b01;
              state    <= START;
`ifdef FHOST_TIMEOUT_EN
              wd_cnt   <= '0;
`endif
            end else begin
              k <= k + 1'b1;
            end
          end
        end

        START: begin
          if (bsy) begin
            ctrl  <= 2'b00;
            state <= WAIT;
          end
        end

        WAIT: begin
          if (!bsy) begin
            res_addr <= k;
            state    <= FETCH;
          end
        end

        FETCH: state <= LATCH;

        LATCH: begin
          out_data  <= res_rdata;
          out_valid <= 1'b1;
          state     <= SEND;
        end

        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (k == LAST) begin
              // Performs the CLR step here so done and the clear pulse share a cycle.
              done  <= 1'b1;
              k     <= '0;
              ctrl  <= 2'b10;
              state <= LOAD;
            end else begin
              k        <= k + 1'b1;
              res_addr <= k + 1'b1;
              state    <= FETCH;
            end
          end
        end

        default: state <= CLR;
      endcase

`ifdef FHOST_TIMEOUT_EN
      // Watchdog overrides the START/WAIT decisions above.
      if (state == START || state == WAIT) begin
        wd_cnt <= wd_cnt + 1'b1;
        if (wd_hit) begin
          err      <= 1'b1;
          ctrl     <= 2'b00;
          res_addr <= '0;
          state    <= CLR;
        end
      end
`endif
    end
  end

endmodule
